// File: rtl/sd_ctrl_pkg.sv
// Shared types for the SD sector arbiter: controller states, captured
// operation kind, sector address width and the round-robin grant rule.
package sd_ctrl_pkg;

  localparam int unsigned LBA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  // With both requesters pending, the one not granted last wins.
  function automatic logic rr_pick(input logic [1:0] pend, input logic last);
    if (&pend) return ~last;
    return pend[1];
  endfunction

endpackage

// File: rtl/sd_req_latch.sv
// Per-requester front end: strobe edge detection, pending flag and
// capture of the operation and sector address.
module sd_req_latch
  import sd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rd,
  input  logic             wr,
  input  logic [LBA_W-1:0] lba,
  input  logic             clear,
  output logic             pend,
  output logic             op,
  output logic [LBA_W-1:0] lba_q
);

  logic rd_d;
  logic wr_d;
  logic rd_rise;
  logic wr_rise;
  logic accept;
  op_t  op_q;

  assign rd_rise = rd & ~rd_d;
  assign wr_rise = wr & ~wr_d;
  // Clearing in the completion cycle frees the slot for an edge in that same cycle.
  assign accept  = (rd_rise | wr_rise) & (~pend | clear);
  assign op      = (op_q == OP_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_d  <= 1'b0;
      wr_d  <= 1'b0;
      pend  <= 1'b0;
      op_q  <= OP_RD;
      lba_q <= '0;
    end else begin
      rd_d <= rd;
      wr_d <= wr;
      if (accept) begin
        pend  <= 1'b1;
        op_q  <= wr_rise ? OP_WR : OP_RD;
        lba_q <= lba;
      end else if (clear) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Arbitrates two sector requesters onto the single hps_io SD sector
// interface, with round-robin grant and an ISSUE-phase timeout.
module sd_sector_arbiter
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic             clk_100m,
  input  logic             reset,
  input  logic             req0_rd,
  input  logic             req0_wr,
  input  logic [LBA_W-1:0] req0_lba,
  input  logic             req1_rd,
  input  logic             req1_wr,
  input  logic [LBA_W-1:0] req1_lba,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  output logic             busy,
  output logic             buf_sel
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [1:0]       pend;
  logic [1:0]       op_wr;
  logic [1:0]       clear;
  logic [LBA_W-1:0] lba_q0;
  logic [LBA_W-1:0] lba_q1;
  logic             grant;
  logic             grant_nx;
  logic             last_grant;
  op_t              op_cur;
  logic             err_flag;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;

  sd_req_latch u_req0 (
    .clk   (clk_100m),
    .rst   (reset),
    .rd    (req0_rd),
    .wr    (req0_wr),
    .lba   (req0_lba),
    .clear (clear[0]),
    .pend  (pend[0]),
    .op    (op_wr[0]),
    .lba_q (lba_q0)
  );

  sd_req_latch u_req1 (
    .clk   (clk_100m),
    .rst   (reset),
    .rd    (req1_rd),
    .wr    (req1_wr),
    .lba   (req1_lba),
    .clear (clear[1]),
    .pend  (pend[1]),
    .op    (op_wr[1]),
    .lba_q (lba_q1)
  );

  assign grant_nx  = rr_pick(pend, last_grant);
  assign timed_out = (cnt == CNT_LAST);

  always_ff @(posedge clk_100m or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // An acknowledge in the last ISSUE cycle still wins over the timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (|pend) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        if (sd_ack)         state_nx = ST_XFER;
        else if (timed_out) state_nx = ST_DONE;
      end
      ST_XFER:  if (!sd_ack) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    busy  = (state != ST_IDLE);
    done0 = 1'b0;
    done1 = 1'b0;
    clear = 2'b00;
    if (state == ST_ISSUE) begin
      sd_rd = (op_cur == OP_RD);
      sd_wr = (op_cur == OP_WR);
    end
    if (state == ST_DONE) begin
      done0    = ~grant;
      done1    = grant;
      clear[0] = ~grant;
      clear[1] = grant;
    end
    err0 = done0 & err_flag;
    err1 = done1 & err_flag;
  end

  always_ff @(posedge clk_100m or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      sd_lba     <= '0;
      op_cur     <= OP_RD;
      err_flag   <= 1'b0;
      cnt        <= '0;
    end else begin
      cnt <= (state == ST_ISSUE) ? cnt + CNT_W'(1) : '0;
      unique case (state)
        ST_IDLE: begin
          if (|pend) begin
            grant    <= grant_nx;
            sd_lba   <= grant_nx ? lba_q1 : lba_q0;
            op_cur   <= (grant_nx ? op_wr[1] : op_wr[0]) ? OP_WR : OP_RD;
            err_flag <= 1'b0;
          end
        end
        ST_ISSUE: if (!sd_ack && timed_out) err_flag <= 1'b1;
        ST_DONE:  last_grant <= grant;
        default:  ;
      endcase
    end
  end

  assign buf_sel = grant;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed and randomized checks of sd_sector_arbiter against a
// transaction-level model of pending requests and round-robin grants.
module tb_sd_sector_arbiter;
  import sd_ctrl_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk_100m = 1'b0;
  logic        reset;
  logic        req0_rd, req0_wr, req1_rd, req1_wr, sd_ack;
  logic [31:0] req0_lba, req1_lba, sd_lba;
  logic        done0, done1, err0, err1, sd_rd, sd_wr, busy, buf_sel;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  bit          m_pend [2];
  bit          m_wr   [2];
  logic [31:0] m_lba  [2];
  int          m_last;

  sd_sector_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_100m (clk_100m),
    .reset    (reset),
    .req0_rd  (req0_rd),
    .req0_wr  (req0_wr),
    .req0_lba (req0_lba),
    .req1_rd  (req1_rd),
    .req1_wr  (req1_wr),
    .req1_lba (req1_lba),
    .done0    (done0),
    .done1    (done1),
    .err0     (err0),
    .err1     (err1),
    .sd_lba   (sd_lba),
    .sd_rd    (sd_rd),
    .sd_wr    (sd_wr),
    .sd_ack   (sd_ack),
    .busy     (busy),
    .buf_sel  (buf_sel)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk_100m);
      #1;
      check("rd_wr_exclusive", sd_rd & sd_wr, 0);
    end
  endtask

  function automatic logic [1:0] rc();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic int pick();
    if (m_pend[0] && m_pend[1]) return 1 - m_last;
    return m_pend[0] ? 0 : 1;
  endfunction

  task automatic model_edge(input int n, input logic [1:0] code, input logic [31:0] l);
    if (code != 2'b00 && !m_pend[n]) begin
      m_pend[n] = 1'b1;
      m_wr[n]   = code[1];
      m_lba[n]  = l;
    end
  endtask

  task automatic model_reset();
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    m_last    = 1;
  endtask

  // code bit0 = rd strobe, bit1 = wr strobe; strobes high for exactly one cycle
  task automatic pulse(input logic [1:0] c0, input logic [1:0] c1,
                       input logic [31:0] l0, input logic [31:0] l1);
    req0_rd = c0[0]; req0_wr = c0[1]; req0_lba = l0;
    req1_rd = c1[0]; req1_wr = c1[1]; req1_lba = l1;
    model_edge(0, c0, l0);
    model_edge(1, c1, l1);
    tick();
    req0_rd = 1'b0; req0_wr = 1'b0; req1_rd = 1'b0; req1_wr = 1'b0;
  endtask

  // retrig: 0 none, 1 granted requester re-strobes in DONE, 2 random strobes in DONE
  task automatic serve(input int unsigned ack_delay, input bit tmo, input bit mid_edges,
                       input int unsigned retrig, output logic seen_sel);
    int          g;
    int unsigned waited;
    logic [31:0] exp_lba;
    logic [1:0]  c;
    g       = pick();
    exp_lba = m_lba[g];
    waited  = 0;
    while (!(sd_rd || sd_wr) && waited < 8) begin
      tick();
      waited++;
    end
    seen_sel = buf_sel;
    check("issue_seen", sd_rd | sd_wr, 1);
    check("issue_rd", sd_rd, !m_wr[g]);
    check("issue_wr", sd_wr, m_wr[g]);
    check("issue_lba", sd_lba, exp_lba);
    check("issue_sel", buf_sel, g);
    if (tmo) begin
      tick(TMO - 1);
      check("tmo_hold", sd_rd | sd_wr, 1);
      tick();
    end else begin
      if (ack_delay > 0) begin
        tick(ack_delay);
        check("ack_wait_hold", sd_rd | sd_wr, 1);
      end
      sd_ack = 1'b1;
      tick();
      check("xfer_bus_low", sd_rd | sd_wr, 0);
      check("xfer_busy", busy, 1);
      if (mid_edges) pulse(rc(), rc(), $urandom(), $urandom());
      else tick();
      check("xfer_lba_stable", sd_lba, exp_lba);
      sd_ack = 1'b0;
      tick();
    end
    check("done_bus_low", sd_rd | sd_wr, 0);
    check("done0", done0, g == 0);
    check("done1", done1, g == 1);
    check("err0", err0, tmo && g == 0);
    check("err1", err1, tmo && g == 1);
    check("done_lba_stable", sd_lba, exp_lba);
    check("done_sel_stable", buf_sel, g);
    m_pend[g] = 1'b0;
    m_last    = g;
    if (retrig == 1) begin
      c = 2'($urandom_range(1, 3));
      if (g == 0) pulse(c, 2'b00, $urandom(), 32'h0);
      else        pulse(2'b00, c, 32'h0, $urandom());
    end else if (retrig == 2) begin
      pulse(rc(), rc(), $urandom(), $urandom());
    end else begin
      tick();
    end
    check("done_over", done0 | done1, 0);
  endtask

  initial begin
    logic        sel;
    int unsigned waited;
    reset = 1'b1; sd_ack = 1'b0;
    req0_rd = 1'b0; req0_wr = 1'b0; req1_rd = 1'b0; req1_wr = 1'b0;
    req0_lba = '0; req1_lba = '0;
    model_reset();
    tick(2);
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_wr", sd_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_err", {err1, err0}, 0);
    check("rst_lba", sd_lba, 0);
    check("rst_sel", buf_sel, 0);
    reset = 1'b0;
    tick();

    // simultaneous edges after reset: requester 0 (write) first, then 1 (read)
    pulse(2'b10, 2'b01, 32'h0000_00A0, 32'h0000_00B1);
    serve(2, 0, 0, 0, sel);
    check("both_first_sel", sel, 0);
    serve(1, 0, 0, 0, sel);
    check("both_second_sel", sel, 1);

    // exact latency and ack handshake timing
    pulse(2'b01, 2'b00, 32'h0000_0010, 32'h0);
    check("lat_t1_rd", sd_rd, 0);
    tick();
    check("lat_t2_rd", sd_rd, 1);
    check("lat_t2_lba", sd_lba, 32'h10);
    check("lat_t2_sel", buf_sel, 0);
    check("lat_t2_busy", busy, 1);
    tick(3);
    sd_ack = 1'b1;
    check("lat_t5_rd", sd_rd, 1);
    tick();
    check("lat_t6_rd", sd_rd, 0);
    tick(2);
    sd_ack = 1'b0;
    check("lat_t8_done", done0, 0);
    tick();
    check("lat_t9_done0", done0, 1);
    check("lat_t9_err0", err0, 0);
    check("lat_t9_done1", done1, 0);
    m_pend[0] = 1'b0;
    m_last    = 0;
    tick();
    check("lat_t10_done0", done0, 0);
    check("lat_t10_busy", busy, 0);

    // continuous retriggering alternates grants
    pulse(2'b01, 2'b01, $urandom(), $urandom());
    for (int i = 0; i < 6; i++) begin
      serve($urandom_range(0, 3), 0, 0, 1, sel);
      check("rr_alternate", sel, (i + 1) % 2);
    end
    serve(0, 0, 0, 0, sel);
    serve(0, 0, 0, 0, sel);
    tick();
    check("rr_drained", busy, 0);

    // ISSUE timeout on requester 1
    pulse(2'b00, 2'b01, 32'h0, 32'h0000_0035);
    serve(0, 1, 0, 0, sel);

    // reset in XFER abandons the transaction
    pulse(2'b10, 2'b00, 32'h0000_0055, 32'h0);
    waited = 0;
    while (!sd_wr && waited < 8) begin
      tick();
      waited++;
    end
    check("rstx_issue_wr", sd_wr, 1);
    sd_ack = 1'b1;
    tick();
    check("rstx_in_xfer", busy, 1);
    reset = 1'b1;
    #1;
    check("rstx_bus", {sd_rd, sd_wr}, 0);
    check("rstx_busy", busy, 0);
    check("rstx_done_now", {done1, done0}, 0);
    sd_ack = 1'b0;
    repeat (2) begin
      tick();
      check("rstx_no_done", {done1, done0}, 0);
    end
    reset = 1'b0;
    model_reset();
    pulse(2'b00, 2'b01, 32'h0, 32'h0000_0077);
    check("rstx_t1_rd", sd_rd, 0);
    tick();
    check("rstx_t2_rd", sd_rd, 1);
    serve(1, 0, 0, 0, sel);

    // randomized traffic
    repeat (40) begin
      if (!m_pend[0] && !m_pend[1]) pulse(rc(), rc(), $urandom(), $urandom());
      if (m_pend[0] || m_pend[1]) begin
        serve($urandom_range(0, 6), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), sel);
      end else begin
        tick();
        check("idle_quiet", busy, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_sector_arbiter.md
SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000000, ISSUE-state cycles before abort (1 s at 100 MHz).
REQ-002 SHALL have port clk_100m  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_rd, req0_wr  in  1 each  requester 0 (save EEPROM) sector read/write strobes.
REQ-005 SHALL have port req0_lba  in  32  requester 0 sector address, valid on strobe rising edge.
REQ-006 SHALL have ports req1_rd, req1_wr, req1_lba  in  1/1/32  requester 1 (FX flash), same meaning.
REQ-007 SHALL have ports done0, done1  out  1 each  one-cycle completion pulse per requester.
REQ-008 SHALL have ports err0, err1  out  1 each  one-cycle timeout flag, coincident with doneN.
REQ-009 SHALL have port sd_lba  out  32  sector address to hps_io.
REQ-010 SHALL have ports sd_rd, sd_wr  out  1 each  sector request to hps_io.
REQ-011 SHALL have port sd_ack  in  1  hps_io transfer acknowledge.
REQ-012 SHALL have port busy  out  1  transaction in progress (state not IDLE).
REQ-013 SHALL have port buf_sel  out  1  index of requester owning sdbuf port B.

Function
REQ-014 SHALL rising-edge detect each reqN_rd/reqN_wr against its previous-cycle value.
REQ-015 SHALL, on an edge with requester N not pending, set pendN, capture op (wr wins if both edges same cycle) and reqN_lba.
REQ-016 SHALL ignore an edge while requester N is already pending or in service.
REQ-017 SHALL implement states IDLE, ISSUE, XFER, DONE.
REQ-018 IDLE: if one pending, grant it; if both, grant the one not granted last (round-robin; requester 0 first after reset); load sd_lba, buf_sel; -> ISSUE.
REQ-019 ISSUE: drive sd_rd or sd_wr high per captured op, hold until sd_ack=1, then drop both and -> XFER.
REQ-020 XFER: wait for sd_ack=0, then -> DONE.
REQ-021 DONE: pulse doneN for granted N one cycle, clear pendN, update last-grant, -> IDLE.
REQ-022 Latency: strobe edge at cycle t with arbiter idle, nothing pending -> sd_rd/sd_wr high at cycle t+2.
REQ-023 ISSUE timeout: counter reaching TIMEOUT_CYCLES-1 -> drop sd_rd/sd_wr, -> DONE with errN=1.
REQ-024 sd_ack high on ISSUE entry SHALL be honoured same cycle (ISSUE lasts exactly one cycle).
REQ-025 sd_lba and buf_sel SHALL stay stable from ISSUE entry through DONE.
REQ-026 A new edge from the granted requester arriving in DONE SHALL be accepted (pendN cleared before set).
REQ-027 sd_rd and sd_wr SHALL never be high together.

Reset
REQ-028 Reset SHALL force IDLE, sd_rd=0, sd_wr=0, sd_lba=0, buf_sel=0, busy=0, doneN=0, errN=0, pendN=0, edge registers=0, last-grant=1, counter=0.
REQ-029 Reset mid-transaction SHALL abandon it with no doneN pulse.

Structure
REQ-030 Package sd_ctrl_pkg SHALL hold state enum, op enum (OP_RD/OP_WR), LBA width constant.
REQ-031 Sub-module sd_req_latch SHALL implement edge detect, pending bit and op/LBA capture; instantiated twice.

Verification
REQ-032 req0_rd edge, lba=0x10, sd_ack high 3 cycles at t+5 -> sd_rd high t+2..first ack cycle, sd_lba=0x10, done0 pulse, err0=0.
REQ-033 req0_wr and req1_rd edges same cycle -> requester 0 served first (sd_wr), then requester 1 (sd_rd), buf_sel 0 then 1.
REQ-034 Both requesters retrigger continuously -> grants alternate 0,1,0,1; no starvation.
REQ-035 TIMEOUT_CYCLES=16, no sd_ack -> sd_rd drops after 16 cycles, done1 and err1 pulse together.
REQ-036 Reset asserted in XFER -> sd_rd/sd_wr/busy low immediately, no doneN; new edge afterwards served normally.
